// File: rtl/display_mode_ctrl.sv
// Display mode FSM: selects what the board display shows, issues time/alarm
// commit pulses and abandons an open edit after an idle timeout in 1 Hz ticks.
module display_mode_ctrl #(
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_set,
  input  logic       btn_alarm,
  input  logic       btn_adj,
  input  logic       sw_cal,
  input  logic       sw_wm,
  output logic       WM,
  output logic       enable,
  output logic       enable_A,
  output logic       switch,
  output logic [2:0] mode,
  output logic       load_time,
  output logic       load_alarm,
  output logic       edit_cancel
);

  typedef enum logic [2:0] {
    S_REAL      = 3'd0,
    S_CAL       = 3'd1,
    S_SET_TIME  = 3'd2,
    S_SET_ALARM = 3'd3,
    S_GAME      = 3'd4
  } state_t;

  // Timeout fires on the TIMEOUT_S-th idle tick, i.e. when the count before
  // that tick has reached TIMEOUT_S-1.
  localparam logic [7:0] LAST_IDLE = 8'(TIMEOUT_S - 1);

  state_t     state;
  state_t     nxt;
  state_t     home;
  logic       set_q;
  logic       alarm_q;
  logic       adj_q;
  logic       set_rise;
  logic       alarm_rise;
  logic       adj_rise;
  logic [7:0] idle_cnt;
  logic       in_edit;
  logic       nxt_edit;
  logic       timeout;
  logic       do_load_t;
  logic       do_load_a;
  logic       do_cancel;

  assign set_rise   = btn_set   & ~set_q;
  assign alarm_rise = btn_alarm & ~alarm_q;
  assign adj_rise   = btn_adj   & ~adj_q;

  always_comb begin
    nxt       = state;
    do_load_t = 1'b0;
    do_load_a = 1'b0;
    do_cancel = 1'b0;
    home      = sw_cal ? S_CAL : S_REAL;
    in_edit   = (state == S_SET_TIME) || (state == S_SET_ALARM);
    timeout   = in_edit && tick_1hz && !adj_rise && (idle_cnt == LAST_IDLE);

    if (sw_wm) begin
      nxt = S_GAME;
    end else begin
      case (state)
        S_GAME: nxt = S_REAL;
        S_REAL: begin
          if (set_rise)        nxt = S_SET_TIME;
          else if (alarm_rise) nxt = S_SET_ALARM;
          else if (sw_cal)     nxt = S_CAL;
        end
        S_CAL: begin
          if (set_rise)        nxt = S_SET_TIME;
          else if (alarm_rise) nxt = S_SET_ALARM;
          else if (!sw_cal)    nxt = S_REAL;
        end
        S_SET_TIME: begin
          if (set_rise) begin
            nxt       = home;
            do_load_t = 1'b1;
          end else if (timeout) begin
            nxt       = home;
            do_cancel = 1'b1;
          end
        end
        S_SET_ALARM: begin
          if (alarm_rise) begin
            nxt       = home;
            do_load_a = 1'b1;
          end else if (timeout) begin
            nxt       = home;
            do_cancel = 1'b1;
          end
        end
        default: nxt = S_REAL;
      endcase
    end

    nxt_edit = (nxt == S_SET_TIME) || (nxt == S_SET_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REAL;
      set_q       <= 1'b1;
      alarm_q     <= 1'b1;
      adj_q       <= 1'b1;
      idle_cnt    <= '0;
      WM          <= 1'b0;
      enable      <= 1'b0;
      enable_A    <= 1'b0;
      switch      <= 1'b0;
      mode        <= '0;
      load_time   <= 1'b0;
      load_alarm  <= 1'b0;
      edit_cancel <= 1'b0;
    end else begin
      state   <= nxt;
      set_q   <= btn_set;
      alarm_q <= btn_alarm;
      adj_q   <= btn_adj;

      // Counter only runs while staying inside an edit state; entering one
      // always starts from zero.
      if (!nxt_edit || (nxt != state) || adj_rise)
        idle_cnt <= '0;
      else if (tick_1hz && (idle_cnt != 8'hFF))
        idle_cnt <= idle_cnt + 8'd1;

      // Selects are registered from the next state so they track the state register.
      WM          <= (nxt == S_GAME);
      enable      <= (nxt == S_SET_TIME);
      enable_A    <= (nxt == S_SET_ALARM);
      switch      <= (nxt == S_CAL);
      mode        <= nxt;
      load_time   <= do_load_t;
      load_alarm  <= do_load_a;
      edit_cancel <= do_cancel;
    end
  end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Table-driven bench for display_mode_ctrl (TIMEOUT_S=4) plus a random
// select-consistency sweep.
module tb_display_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_set = 1'b1;
  logic       btn_alarm = 1'b0;
  logic       btn_adj = 1'b0;
  logic       sw_cal = 1'b0;
  logic       sw_wm = 1'b0;
  logic       WM, enable, enable_A, switch;
  logic [2:0] mode;
  logic       load_time, load_alarm, edit_cancel;

  int compared = 0;
  int mismatched = 0;

  display_mode_ctrl #(.TIMEOUT_S(4)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_set(btn_set), .btn_alarm(btn_alarm), .btn_adj(btn_adj),
    .sw_cal(sw_cal), .sw_wm(sw_wm),
    .WM(WM), .enable(enable), .enable_A(enable_A), .switch(switch),
    .mode(mode), .load_time(load_time), .load_alarm(load_alarm),
    .edit_cancel(edit_cancel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, s, a, j, t, c, w;
    logic [2:0] m;
    logic       lt, la, ec;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, s, a, j, t, c, w,
                     input logic [2:0] m, input logic lt, la, ec);
    vec_t v;
    v.r = r; v.s = s; v.a = a; v.j = j; v.t = t; v.c = c; v.w = w;
    v.m = m; v.lt = lt; v.la = la; v.ec = ec;
    vecs.push_back(v);
  endtask

  // {WM, enable, enable_A, switch} required for a mode code
  function automatic logic [3:0] sel_of(input logic [2:0] m);
    case (m)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0100;
      3'd3:    return 4'b0010;
      3'd4:    return 4'b1000;
      default: return 4'b1111;
    endcase
  endfunction

  initial begin
    logic [6:0] got_ms;
    logic [6:0] exp_ms;
    logic [2:0] got_p;
    logic [2:0] exp_p;
    logic       prev_pulse;

    //   r  s  a  j  t  c  w   mode lt la ec
    add(1, 1, 0, 0, 0, 0, 0,  3'd0, 0, 0, 0); // 0 reset, set held
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0); // held through reset: no event
    add(0, 0, 0, 0, 0, 0, 0,  3'd0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0,  3'd2, 0, 0, 0); // press -> SET_TIME
    add(0, 0, 0, 0, 0, 0, 0,  3'd2, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0,  3'd0, 1, 0, 0); // commit
    add(0, 0, 0, 0, 0, 0, 0,  3'd0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0,  3'd2, 0, 0, 0); // set+alarm: set wins
    add(0, 0, 0, 0, 0, 0, 0,  3'd2, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0,  3'd2, 0, 0, 0); // alarm ignored in SET_TIME
    add(0, 0, 0, 0, 0, 0, 0,  3'd2, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0,  3'd1, 1, 0, 0); // commit with cal -> CAL
    add(0, 0, 0, 0, 0, 1, 0,  3'd1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3'd0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0,  3'd3, 0, 0, 0); // SET_ALARM, idle timeout
    add(0, 0, 0, 0, 1, 0, 0,  3'd3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3'd3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3'd3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3'd3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3'd0, 0, 0, 1); // 4th tick
    add(0, 0, 0, 0, 0, 0, 0,  3'd0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0,  3'd3, 0, 0, 0); // adj after tick 3
    add(0, 0, 0, 0, 1, 0, 0,  3'd3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3'd3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3'd3, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0,  3'd3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3'd3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3'd3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3'd3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3'd0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0,  3'd2, 0, 0, 0); // adj coincident with 4th tick
    add(0, 0, 0, 0, 1, 0, 0,  3'd2, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3'd2, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3'd2, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0,  3'd2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3'd2, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3'd2, 0, 0, 0); // commit vs timeout
    add(0, 0, 0, 0, 1, 0, 0,  3'd2, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  3'd2, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0,  3'd0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3'd0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0,  3'd2, 0, 0, 0); // game override
    add(0, 0, 0, 0, 0, 0, 1,  3'd4, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1,  3'd4, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1,  3'd4, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3'd0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0,  3'd3, 0, 0, 0); // reset mid-edit
    add(1, 0, 0, 0, 0, 0, 0,  3'd0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3'd0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  3'd1, 0, 0, 0); // CAL, alarm commit back to CAL
    add(0, 0, 1, 0, 0, 1, 0,  3'd3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  3'd3, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 0,  3'd1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3'd0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0,  3'd3, 0, 0, 0); // set ignored in SET_ALARM
    add(0, 1, 0, 0, 0, 0, 0,  3'd3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3'd3, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0,  3'd0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3'd0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].r; btn_set = vecs[i].s; btn_alarm = vecs[i].a;
      btn_adj = vecs[i].j; tick_1hz = vecs[i].t; sw_cal = vecs[i].c;
      sw_wm = vecs[i].w;
      @(posedge clk);
      #1;
      got_ms = {mode, WM, enable, enable_A, switch};
      exp_ms = {vecs[i].m, sel_of(vecs[i].m)};
      compared++;
      if (got_ms !== exp_ms) begin
        mismatched++;
        $display("FAIL vec%0d mode/selects: got %b required %b", i, got_ms, exp_ms);
      end
      got_p = {load_time, load_alarm, edit_cancel};
      exp_p = {vecs[i].lt, vecs[i].la, vecs[i].ec};
      compared++;
      if (got_p !== exp_p) begin
        mismatched++;
        $display("FAIL vec%0d pulses lt/la/ec: got %b required %b", i, got_p, exp_p);
      end
    end

    // Random sweep: selects must always match mode, pulses never back to back.
    prev_pulse = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 499) == 0);
      btn_set   = ($urandom_range(0, 3) == 0);
      btn_alarm = ($urandom_range(0, 3) == 0);
      btn_adj   = ($urandom_range(0, 7) == 0);
      tick_1hz  = ($urandom_range(0, 2) == 0);
      sw_cal    = ($urandom_range(0, 9) < 4);
      sw_wm     = ($urandom_range(0, 19) == 0);
      @(posedge clk);
      #1;
      compared++;
      if ({WM, enable, enable_A, switch} !== sel_of(mode)) begin
        mismatched++;
        $display("FAIL rand%0d one-hot: got sel %b mode %0d required sel %b",
                 n, {WM, enable, enable_A, switch}, mode, sel_of(mode));
      end
      if (prev_pulse) begin
        compared++;
        if ((load_time | load_alarm | edit_cancel) !== 1'b0) begin
          mismatched++;
          $display("FAIL rand%0d pulse-gap: got %b required 000", n,
                   {load_time, load_alarm, edit_cancel});
        end
      end
      prev_pulse = load_time | load_alarm | edit_cancel;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
